// File: rtl/sr_pkg.sv
// Shared types and default sizing for the SR latch pulse driver.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } sr_state_t;

    localparam int SR_PULSE_W  = 2;
    localparam int SR_SETTLE_W = 1;
    localparam int SR_CNT_W    = 4;

endpackage

// File: rtl/sr_down_counter.sv
// Loadable down-counter with terminal-count flag; times both the pulse and
// settle windows of the SR driver. Holds at zero once it gets there.
module sr_down_counter
    import sr_pkg::*;
#(
    parameter int CNT_W = SR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Set/reset pulse driver for an asynchronous SR NOR latch with readback.
// Optional build macro: SR_SKIP_REDUNDANT_EN -- skip the pulse when the
// latch already holds the requested value.
//
// state  | meaning
// IDLE   | S=R=0, waiting for REQ
// PULSE  | driving S (d=1) or R (d=0) for PULSE_W cycles
// SETTLE | S=R=0 for SETTLE_W cycles before readback
// CHECK  | ACK cycle; ERR reflects readback taken on entry
module sr_pulse_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W  = SR_PULSE_W,
    parameter int SETTLE_W = SR_SETTLE_W,
    parameter int CNT_W    = SR_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ,
    input  logic D,
    output logic S,
    output logic R,
    input  logic Q_fb,
    input  logic Q_not_fb,
    output logic BUSY,
    output logic ACK,
    output logic ERR
);

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_W == 0) ? '0 : CNT_W'(SETTLE_W - 1);

    sr_state_t        state, state_nxt;
    logic             d_q, d_nxt;
    logic             s_nxt, r_nxt, busy_nxt, ack_nxt, err_nxt;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             fb_match;
    logic             skip_req;

    // Case equality so an unknown readback is treated as a mismatch.
    assign fb_match = (Q_fb === d_q) && (Q_not_fb === ~d_q);

`ifdef SR_SKIP_REDUNDANT_EN
    assign skip_req = (Q_fb === D) && (Q_not_fb === ~D);
`else
    assign skip_req = 1'b0;
`endif

    sr_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Next-state and next-output decode; S and R are only ever driven as a
    // complementary pair, so they can never both be high.
    always_comb begin
        state_nxt    = state;
        d_nxt        = d_q;
        s_nxt        = 1'b0;
        r_nxt        = 1'b0;
        busy_nxt     = 1'b0;
        ack_nxt      = 1'b0;
        err_nxt      = ERR;
        cnt_load     = 1'b0;
        cnt_load_val = PULSE_LOAD;
        cnt_en       = 1'b0;
        unique case (state)
            IDLE: begin
                if (REQ) begin
                    d_nxt    = D;
                    err_nxt  = 1'b0;
                    busy_nxt = 1'b1;
                    if (skip_req) begin
                        state_nxt = CHECK;
                        ack_nxt   = 1'b1;
                    end else begin
                        state_nxt    = PULSE;
                        cnt_load     = 1'b1;
                        cnt_load_val = PULSE_LOAD;
                        s_nxt        = D;
                        r_nxt        = ~D;
                    end
                end
            end
            PULSE: begin
                busy_nxt = 1'b1;
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                    s_nxt  = d_q;
                    r_nxt  = ~d_q;
                end else if (SETTLE_W == 0) begin
                    state_nxt = CHECK;
                    ack_nxt   = 1'b1;
                    err_nxt   = ~fb_match;
                end else begin
                    state_nxt    = SETTLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                busy_nxt = 1'b1;
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else begin
                    state_nxt = CHECK;
                    ack_nxt   = 1'b1;
                    err_nxt   = ~fb_match;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops S/R immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            d_q   <= 1'b0;
            S     <= 1'b0;
            R     <= 1'b0;
            BUSY  <= 1'b0;
            ACK   <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            d_q   <= d_nxt;
            S     <= s_nxt;
            R     <= r_nxt;
            BUSY  <= busy_nxt;
            ACK   <= ack_nxt;
            ERR   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: NOR latch model on S/R, cycle-index reference
// model compared every cycle, plus pinned literal scenarios.
module tb_sr_pulse_driver;

    localparam int P  = 2;
    localparam int SW = 1;
`ifdef SR_SKIP_REDUNDANT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ = 1'b0;
    logic D   = 1'b0;
    logic S, R, BUSY, ACK, ERR;
    logic Q_fb, Q_not_fb;
    logic q_lat    = 1'b0;
    logic force_q0 = 1'b0;

    logic REQ0 = 1'b0;
    logic D0   = 1'b0;
    logic S0, R0, BUSY0, ACK0, ERR0;
    logic q0_lat = 1'b0;
    logic q0_not;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Behavioural SR latch: S sets, R resets, otherwise holds.
    always @(S or R) begin
        if (S && !R) q_lat = 1'b1;
        else if (R && !S) q_lat = 1'b0;
    end
    always @(S0 or R0) begin
        if (S0 && !R0) q0_lat = 1'b1;
        else if (R0 && !S0) q0_lat = 1'b0;
    end

    assign Q_fb     = force_q0 ? 1'b0 : q_lat;
    assign Q_not_fb = ~q_lat;
    assign q0_not   = ~q0_lat;

    sr_pulse_driver #(.PULSE_W(P), .SETTLE_W(SW), .CNT_W(4)) u_dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .D(D), .S(S), .R(R),
        .Q_fb(Q_fb), .Q_not_fb(Q_not_fb), .BUSY(BUSY), .ACK(ACK), .ERR(ERR)
    );

    sr_pulse_driver #(.PULSE_W(3), .SETTLE_W(0), .CNT_W(4)) u_dut0 (
        .CLK(CLK), .RST(RST), .REQ(REQ0), .D(D0), .S(S0), .R(R0),
        .Q_fb(q0_lat), .Q_not_fb(q0_not), .BUSY(BUSY0), .ACK(ACK0), .ERR(ERR0)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k_m is the cycle index since acceptance (0 = idle),
    // len_m the cycle index that carries ACK.
    int k_m   = 0;
    int len_m = 0;
    bit dm    = 1'b0;
    bit skip_m = 1'b0;
    bit err_m = 1'b0;

    always @(posedge CLK or posedge RST) begin
        int k, len;
        bit d, sk, e;
        k = k_m; len = len_m; d = dm; sk = skip_m; e = err_m;
        if (RST) begin
            k = 0;
            e = 1'b0;
        end else if (k == 0) begin
            if (REQ === 1'b1) begin
                d   = D;
                e   = 1'b0;
                sk  = SKIP && (Q_fb === D) && (Q_not_fb === ~D);
                len = sk ? 1 : P + SW + 1;
                k   = 1;
            end
        end else if (k == len) begin
            k = 0;
        end else begin
            k = k + 1;
            if (k == len) e = !((Q_fb === d) && (Q_not_fb === ~d));
        end
        k_m <= k; len_m <= len; dm <= d; skip_m <= sk; err_m <= e;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("s",    S,    (k_m > 0) && !skip_m && (k_m <= P) && dm);
        chk("r",    R,    (k_m > 0) && !skip_m && (k_m <= P) && !dm);
        chk("busy", BUSY, k_m > 0);
        chk("ack",  ACK,  (k_m > 0) && (k_m == len_m));
        chk("err",  ERR,  err_m);
        chk("s_and_r", S & R, 1'b0);
        chk("s0_and_r0", S0 & R0, 1'b0);
    end

    // One write with literal per-cycle expectations (PULSE_W=2, SETTLE_W=1).
    task automatic pinned_write(input logic d, input logic exp_pulse,
                                input int ack_cyc, input logic exp_err);
        REQ = 1'b1;
        D   = d;
        for (int c = 1; c <= ack_cyc; c++) begin
            @(negedge CLK);
            REQ = 1'b0;
            D   = ~d;
            chk("pin_s",    S,    exp_pulse && d && (c <= 2));
            chk("pin_r",    R,    exp_pulse && !d && (c <= 2));
            chk("pin_busy", BUSY, 1'b1);
            chk("pin_ack",  ACK,  c == ack_cyc);
            if (c == ack_cyc) chk("pin_err", ERR, exp_err);
        end
        @(negedge CLK);
        chk("pin_idle_busy", BUSY, 1'b0);
    endtask

    initial begin
        int acks;
        logic dd;
        repeat (3) @(negedge CLK);
        chk("rst_s", S, 1'b0);
        chk("rst_r", R, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ack", ACK, 1'b0);
        chk("rst_err", ERR, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        pinned_write(1'b1, 1'b1, 4, 1'b0);
        chk("latch_set", q_lat, 1'b1);
        pinned_write(1'b1, !SKIP, SKIP ? 1 : 4, 1'b0);
        chk("latch_still_set", q_lat, 1'b1);
        pinned_write(1'b0, 1'b1, 4, 1'b0);
        chk("latch_reset", q_lat, 1'b0);

        force_q0 = 1'b1;
        pinned_write(1'b1, 1'b1, 4, 1'b1);
        force_q0 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("err_held", ERR, 1'b1);
        REQ = 1'b1;
        D   = 1'b0;
        @(negedge CLK);
        REQ = 1'b0;
        chk("err_cleared", ERR, 1'b0);
        repeat (4) @(negedge CLK);

        // REQ held high with D toggling every cycle.
        acks = 0;
        REQ  = 1'b1;
        D    = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            D = ~D;
            if (ACK) acks++;
        end
        REQ = 1'b0;
        chk_int("held_acks", acks, 4);
        repeat (6) @(negedge CLK);

        for (int i = 0; i < 400; i++) begin
            REQ      = ($urandom_range(0, 2) == 0);
            D        = $urandom_range(0, 1);
            force_q0 = ($urandom_range(0, 9) == 0);
            @(negedge CLK);
        end
        REQ      = 1'b0;
        force_q0 = 1'b0;
        repeat (6) @(negedge CLK);

        // Reset in the middle of a pulse.
        dd  = ~q_lat;
        REQ = 1'b1;
        D   = dd;
        @(negedge CLK);
        REQ = 1'b0;
        chk("pre_rst_pulse", S | R, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_s", S, 1'b0);
        chk("mid_rst_r", R, 1'b0);
        chk("mid_rst_busy", BUSY, 1'b0);
        chk("mid_rst_ack", ACK, 1'b0);
        chk("mid_rst_err", ERR, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        dd = ~q_lat;
        pinned_write(dd, 1'b1, 4, 1'b0);

        // SETTLE_W=0, PULSE_W=3 instance: ACK in cycle PULSE_W+1.
        REQ0 = 1'b1;
        D0   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            REQ0 = 1'b0;
            D0   = 1'b0;
            chk("s0", S0, c <= 3);
            chk("r0", R0, 1'b0);
            chk("busy0", BUSY0, 1'b1);
            chk("ack0", ACK0, c == 4);
        end
        chk("err0", ERR0, 1'b0);
        chk("latch0_set", q0_lat, 1'b1);
        @(negedge CLK);
        chk("ack0_done", ACK0, 1'b0);
        chk("busy0_done", BUSY0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
